// File: rtl/joypad_reg.sv
// joypad_reg: Game Boy P1/JOYP register at 0xFF00.
// Sits downstream of the eight per-button debouncers. It synchronizes the raw
// button levels and stretches one-cycle press pulses so that a short tap stays
// visible for HOLD_CYCLES cycles. It also raises a one-cycle joypad interrupt.
// Optional build macro: JOYPAD_SELECT_IRQ_EN. When it is defined, only presses
// in the currently selected group(s) raise the interrupt.
// Bit map for the button vectors: 0 right, 1 left, 2 up, 3 down, 4 A, 5 B,
// 6 select, 7 start.
module joypad_reg #(
    parameter int HOLD_CYCLES = 140448,
    parameter int HOLD_WIDTH  = $clog2(HOLD_CYCLES + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  button_level,
    input  logic [7:0]  button_pressed,
    input  logic [15:0] addr,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        hit,
    output logic        joypad_irq
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(HOLD_CYCLES);
    localparam logic [HOLD_WIDTH-1:0] CNT_ONE   = HOLD_WIDTH'(1);
    localparam logic [15:0]           JOYP_ADDR = 16'hFF00;

    logic [7:0]            lvl_meta;
    logic [7:0]            lvl_s;
    logic [1:0]            select;
    logic [HOLD_WIDTH-1:0] cnt [8];
    logic [7:0]            held;
    logic [7:0]            down;
    logic [7:0]            group_mask;
    logic [7:0]            irq_src;
    logic [3:0]            lines_low;
    logic                  unused_wr_bits;

    // Address decode is purely combinational from the bus address.
    assign hit = (addr == JOYP_ADDR);

    // Two-flop synchronizer for the asynchronous raw button levels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lvl_meta <= 8'h00;
            lvl_s    <= 8'h00;
        end else begin
            lvl_meta <= button_level;
            lvl_s    <= lvl_meta;
        end
    end

    // Select register: only bits 5:4 of a write to 0xFF00 are kept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            select <= 2'b11;
        end else if (wr_en && hit) begin
            select <= wr_data[5:4];
        end
    end

    // The remaining write bits are read-only or unused in this register.
    assign unused_wr_bits = ^{wr_data[7:6], wr_data[3:0]};

    // Per-button hold counters. A press reloads the counter, even mid-hold.
    // Otherwise the counter counts down and stops at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (button_pressed[i]) begin
                    cnt[i] <= HOLD_LOAD;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // A button is held down while its stretch counter is still running.
    always_comb begin
        held = 8'h00;
        for (int i = 0; i < 8; i++) begin
            held[i] = (cnt[i] != '0);
        end
    end

    assign down = lvl_s | held;

    // A group is selected when its select bit is low.
    // select[0] controls the directions and select[1] controls the buttons.
    assign group_mask = {{4{~select[1]}}, {4{~select[0]}}};

    // A line reads low if any button in a selected group on that line is down.
    assign lines_low = (down[3:0] & group_mask[3:0]) | (down[7:4] & group_mask[7:4]);

    assign rd_data = hit ? {2'b11, select, ~lines_low} : 8'h00;

`ifdef JOYPAD_SELECT_IRQ_EN
    // Only presses in a selected group can pull a line low, so only those interrupt.
    assign irq_src = button_pressed & group_mask;
`else
    // Any press interrupts, whatever the select setting.
    assign irq_src = button_pressed;
`endif

    // Registered interrupt pulse, one cycle after the press pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            joypad_irq <= 1'b0;
        end else begin
            joypad_irq <= |irq_src;
        end
    end

endmodule

// File: tb/tb_joypad_reg.sv
// Testbench for joypad_reg. The design is built with a short hold time.
// A timestamp-based model predicts rd_data, hit and joypad_irq on every
// cycle. Directed literal checks pin the model to hand-computed values.
module tb_joypad_reg;

    localparam int HOLD = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  button_level;
    logic [7:0]  button_pressed;
    logic [15:0] addr;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        hit;
    logic        joypad_irq;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit model_ready  = 1'b0;

    // Model state: the edge count, the edge of each button's last press,
    // the levels seen at recent edges, the select value and the expected irq.
    longint     edges;
    longint     last_press [8];
    logic [7:0] level_seen [$];
    logic [1:0] m_sel;
    logic       m_irq;
    logic [7:0] gate;

    always #5 clock = ~clock;

    joypad_reg #(.HOLD_CYCLES(HOLD)) dut (
        .clock          (clock),
        .reset          (reset),
        .button_level   (button_level),
        .button_pressed (button_pressed),
        .addr           (addr),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .rd_data        (rd_data),
        .hit            (hit),
        .joypad_irq     (joypad_irq)
    );

    // Compare one value against its requirement and keep the counts.
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual %02h, required %02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive a new set of inputs just after a rising edge.
    task automatic applyStimulus(input logic [15:0] a, input logic we, input logic [7:0] wd,
                                 input logic [7:0] lvl, input logic [7:0] prs);
        @(posedge clock);
        #2;
        addr           = a;
        wr_en          = we;
        wr_data        = wd;
        button_level   = lvl;
        button_pressed = prs;
    endtask

    // Compute the expected read value from the register rules.
    function automatic logic [7:0] expected_rd();
        logic [7:0] synced;
        logic [7:0] is_down;
        logic [3:0] line;
        if (addr != 16'hFF00) return 8'h00;
        synced = (level_seen.size() == 2) ? level_seen[0] : 8'h00;
        for (int i = 0; i < 8; i++) begin
            is_down[i] = synced[i] || ((edges - last_press[i]) < HOLD);
        end
        line = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            if (m_sel[0] == 1'b0 && is_down[b])     line[b] = 1'b1;
            if (m_sel[1] == 1'b0 && is_down[b + 4]) line[b] = 1'b1;
        end
        return {2'b11, m_sel, ~line};
    endfunction

    // Model update on each rising edge. Reset clears the model asynchronously.
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            edges = 0;
            for (int i = 0; i < 8; i++) last_press[i] = -1000000;
            level_seen.delete();
            m_sel = 2'b11;
            m_irq = 1'b0;
        end else begin
            edges++;
            for (int i = 0; i < 8; i++) begin
`ifdef JOYPAD_SELECT_IRQ_EN
                gate[i] = (i < 4) ? (m_sel[0] == 1'b0) : (m_sel[1] == 1'b0);
`else
                gate[i] = 1'b1;
`endif
            end
            m_irq = |(button_pressed & gate);
            for (int i = 0; i < 8; i++) begin
                if (button_pressed[i]) last_press[i] = edges;
            end
            level_seen.push_back(button_level);
            if (level_seen.size() > 2) void'(level_seen.pop_front());
            if (wr_en && addr == 16'hFF00) m_sel = wr_data[5:4];
        end
    end

    // Compare the outputs against the model on every falling edge.
    initial forever begin
        @(negedge clock);
        if (model_ready) begin
            checkOutput("model rd_data", rd_data, expected_rd());
            checkOutput("model hit", {7'b0, hit}, {7'b0, addr == 16'hFF00});
            checkOutput("model irq", {7'b0, joypad_irq}, {7'b0, m_irq});
        end
    end

    // Stop the run if the stimulus never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        addr = 16'hFF00; wr_en = 1'b0; wr_data = 8'h00;
        button_level = 8'h00; button_pressed = 8'h00;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        model_ready = 1'b1;

        // Reset state, then a read of another address.
        @(negedge clock);
        #1;
        checkOutput("reset rd", rd_data, 8'hFF);
        checkOutput("reset hit", {7'b0, hit}, 8'h01);
        checkOutput("reset irq", {7'b0, joypad_irq}, 8'h00);
        addr = 16'hFF01;
        #1;
        checkOutput("other rd", rd_data, 8'h00);
        checkOutput("other hit", {7'b0, hit}, 8'h00);

        // Directions selected, then a short tap on up.
        applyStimulus(16'hFF00, 1'b1, 8'h20, 8'h00, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h04);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("tap visible", rd_data, 8'hEB);
        checkOutput("tap irq", {7'b0, joypad_irq}, 8'h01);
        for (int j = 1; j < HOLD; j++) begin
            @(negedge clock);
            checkOutput("tap held", rd_data, 8'hEB);
            if (j == 1) checkOutput("tap irq end", {7'b0, joypad_irq}, 8'h00);
        end
        @(negedge clock);
        checkOutput("tap expired", rd_data, 8'hEF);

        // Buttons selected; start is held by level only.
        applyStimulus(16'hFF00, 1'b1, 8'h10, 8'h00, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h80, 8'h00);
        @(negedge clock);
        @(negedge clock);
        checkOutput("level latency", rd_data, 8'hDF);
        @(negedge clock);
        checkOutput("level start", rd_data, 8'hD7);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        @(negedge clock);
        checkOutput("release latency", rd_data, 8'hD7);
        @(negedge clock);
        checkOutput("level released", rd_data, 8'hDF);

        // Both groups selected, with right and A down.
        applyStimulus(16'hFF00, 1'b1, 8'h00, 8'h11, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h11, 8'h00);
        @(negedge clock);
        @(negedge clock);
        checkOutput("both groups", rd_data, 8'hCE);
        applyStimulus(16'hFF00, 1'b1, 8'h30, 8'h11, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h11, 8'h00);
        @(negedge clock);
        checkOutput("none selected", rd_data, 8'hFF);
        applyStimulus(16'hFF01, 1'b1, 8'h00, 8'h11, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("foreign write", rd_data, 8'hFF);

        // Two presses on right, half a hold apart: the second press reloads the counter.
        applyStimulus(16'hFF00, 1'b1, 8'h20, 8'h00, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h01);
        repeat (HOLD / 2 - 1) applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h01);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("reload start", rd_data, 8'hEE);
        for (int j = HOLD / 2 + 1; j < HOLD / 2 + HOLD; j++) begin
            @(negedge clock);
            checkOutput("reload held", rd_data, 8'hEE);
        end
        @(negedge clock);
        checkOutput("reload expired", rd_data, 8'hEF);

        // Reset during a hold clears the hold immediately.
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h01);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clock);
        checkOutput("before reset", rd_data, 8'hEE);
        #1 reset = 1'b1;
        #1;
        checkOutput("mid-hold reset", rd_data, 8'hFF);
        checkOutput("mid-hold irq", {7'b0, joypad_irq}, 8'h00);
        @(posedge clock);
        #2 reset = 1'b0;
        applyStimulus(16'hFF00, 1'b1, 8'h20, 8'h00, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("hold cleared", rd_data, 8'hEF);

        // Interrupts with only the directions selected.
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h10);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
`ifdef JOYPAD_SELECT_IRQ_EN
        checkOutput("A irq gated", {7'b0, joypad_irq}, 8'h00);
`else
        checkOutput("A irq", {7'b0, joypad_irq}, 8'h01);
`endif
        @(negedge clock);
        checkOutput("A irq end", {7'b0, joypad_irq}, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h01);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("right irq", {7'b0, joypad_irq}, 8'h01);
        @(negedge clock);
        checkOutput("right irq end", {7'b0, joypad_irq}, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h0F);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("multi irq", {7'b0, joypad_irq}, 8'h01);
        @(negedge clock);
        checkOutput("multi irq end", {7'b0, joypad_irq}, 8'h00);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h01);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h02);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("back-to-back irq", {7'b0, joypad_irq}, 8'h01);
        @(negedge clock);
        checkOutput("back-to-back end", {7'b0, joypad_irq}, 8'h00);

        // A write and a press in the same cycle: the irq uses the old select.
        applyStimulus(16'hFF00, 1'b1, 8'h10, 8'h00, 8'h10);
        applyStimulus(16'hFF00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("write+press rd", rd_data, 8'hDE);
`ifdef JOYPAD_SELECT_IRQ_EN
        checkOutput("write+press irq", {7'b0, joypad_irq}, 8'h00);
`else
        checkOutput("write+press irq", {7'b0, joypad_irq}, 8'h01);
`endif

        repeat (4) @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
